// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage and IF/ID pipeline register of a
//               5-stage MIPS pipeline. Owns PC_F, runs a single-outstanding
//               instruction-memory handshake with wait states, redirects on
//               branch/jump resolved in decode and inserts bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        PCSrc_D,
  input  logic        Jump_D,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_ready,
  output logic [31:0] Instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D
);

  // FETCH  : request outstanding at PC_F
  // HOLD   : word returned while fetch was stalled, parked in hold_buf
  // DISCARD: finishing a request made obsolete by a redirect
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] hold_buf;
  logic [31:0] daddr;

  logic        stall_f_eff;
  logic        redirect;
  logic [31:0] branch_off;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] deliver_word;

  // A stalled decode stage must also freeze fetch, otherwise a word is lost.
  assign stall_f_eff = Stall_F | Stall_D;
  assign redirect    = (PCSrc_D | Jump_D) & ~Stall_D;
  assign branch_off  = {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
  // Jump wins over branch when both are flagged.
  assign target      = Jump_D ? {PCPlus4_D[31:28], Instr_D[25:0], 2'b00}
                              : PCPlus4_D + branch_off;
  assign pc_plus4    = pc_f + 32'd4;

  // The request stays up in DISCARD so the orphaned access can complete.
  assign inst_req  = (state != HOLD);
  assign inst_addr = (state == DISCARD) ? daddr : pc_f;

  // Decide whether a word moves into IF/ID this cycle, and which word.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = inst_rdata;
    case (state)
      FETCH: begin
        deliver = inst_ready & ~redirect & ~stall_f_eff;
      end
      HOLD: begin
        deliver      = ~redirect & ~stall_f_eff;
        deliver_word = hold_buf;
      end
      default: begin
        deliver = 1'b0;
      end
    endcase
  end

  // Fetch FSM, PC update and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc_f      <= RESET_PC;
      hold_buf  <= 32'd0;
      daddr     <= 32'd0;
      Instr_D   <= 32'd0;
      PCPlus4_D <= 32'd0;
      Valid_D   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (inst_ready) begin
            if (redirect) begin
              pc_f <= target;
            end else if (stall_f_eff) begin
              hold_buf <= inst_rdata;
              state    <= HOLD;
            end
          end else if (redirect) begin
            daddr <= pc_f;
            pc_f  <= target;
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_f  <= target;
            state <= FETCH;
          end else if (!stall_f_eff) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (redirect) begin
            pc_f <= target;
          end
          if (inst_ready) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase

      // deliver never coincides with redirect, so this cannot clash above.
      if (deliver) begin
        pc_f <= pc_plus4;
      end

      if (Stall_D) begin
        Instr_D   <= Instr_D;
        PCPlus4_D <= PCPlus4_D;
        Valid_D   <= Valid_D;
      end else if (deliver) begin
        Instr_D   <= deliver_word;
        PCPlus4_D <= pc_plus4;
        Valid_D   <= 1'b1;
      end else begin
        // Bubble: all-zero word decodes as sll $0,$0,0.
        Instr_D   <= 32'd0;
        PCPlus4_D <= 32'd0;
        Valid_D   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of decode and its controller.
- Owns PC_F and drives a single-outstanding-request instruction-memory handshake tolerating wait states.
- Computes branch and jump targets from the instruction held in decode, and redirects on PCSrc_D/Jump_D from the controller.
- Delivers Instr_D and PCPlus4_D, inserting bubbles on flush or memory wait.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
Stall_F  in  1  hazard unit: hold PC / fetch result
Stall_D  in  1  hazard unit: hold IF/ID register
PCSrc_D  in  1  controller: taken branch in decode
Jump_D  in  1  controller: jump in decode
inst_req  out  1  imem request
inst_addr  out  32  imem word address (byte address, [1:0]=00)
inst_rdata  in  32  imem data, valid in the cycle inst_ready=1
inst_ready  in  1  imem completes current request
Instr_D  out  32  IF/ID instruction
PCPlus4_D  out  32  IF/ID PC+4
Valid_D  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- redirect = (PCSrc_D | Jump_D) & ~Stall_D.
- target:
  - Jump_D=1 -> {PCPlus4_D[31:28], Instr_D[25:0], 2'b00}.
  - Else -> PCPlus4_D + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00}.
  - Jump has priority over branch. All adds are mod 2^32.
- Stall_D=1 with Stall_F=0 is treated as Stall_F=1.
- Reset values: PC_F=RESET_PC, state=FETCH, Instr_D=0, PCPlus4_D=0, Valid_D=0, hold buffer=0, discard addr=0.
- After rst deasserts, the first cycle drives inst_req=1, inst_addr=RESET_PC.
- The imem shares rst; a transaction in flight at rst is abandoned.
- Handshake rules:
  - inst_req/inst_addr stay stable until inst_ready.
  - inst_ready is ignored when inst_req=0.
  - Zero-wait response is allowed: ready can arrive in the same cycle as req.
- deliver(x) means: if ~Stall_D, IF/ID <= {x, PC_F+4, Valid=1} and PC_F <= PC_F+4.
- FSM states:
  - FETCH: req=1, addr=PC_F.
    - ready & redirect -> drop rdata; PC_F<=target; stay FETCH.
    - ready & Stall_F -> hold<=rdata; go HOLD.
    - ready otherwise -> deliver(rdata); stay FETCH.
    - ~ready & redirect -> daddr<=PC_F; PC_F<=target; go DISCARD.
    - ~ready otherwise -> stay.
  - HOLD: req=0.
    - redirect -> drop hold; PC_F<=target; go FETCH.
    - ~Stall_F -> deliver(hold); go FETCH.
  - DISCARD: req=1, addr=daddr.
    - Completes an orphaned request. On ready, drop rdata and go FETCH.
    - A further redirect updates PC_F<=target without changing state.
- IF/ID register update (priority order):
  1. rst
  2. Stall_D=1: hold all fields.
  3. redirect: load bubble (Instr_D=0, i.e. sll nop; PCPlus4_D=0; Valid_D=0).
  4. delivery: load {instr, PC_F+4, 1}.
  5. Otherwise: load bubble.
- No branch delay slot: the instruction fetched behind a taken branch/jump is always squashed.
- Latency: ready in cycle N -> Instr_D visible in cycle N+1 (if not stalled).
- Throughput is 1 instruction/cycle with zero-wait memory.
- PC wrap: PC_F=32'hFFFF_FFFC advances to 0.

Test Plan:
1. rst 1 cycle, inst_ready=1 always, imem[0..3] = 0x2001_0005, 0x2002_0007, 0x0022_1820, 0x0000_0000 -> inst_addr 0,4,8,C on consecutive cycles; Instr_D follows one cycle later with PCPlus4_D 4,8,C,10 and Valid_D=1.
2. inst_ready delayed 2 cycles per fetch -> inst_req and inst_addr stable through the wait; Valid_D=0 bubble in each wait cycle; every instruction is delivered exactly once, in order.
3. Stall_F=Stall_D=1 for 3 cycles while ready=1 -> state HOLD, inst_req=0, Instr_D unchanged; after release, the buffered word appears next cycle and PC_F advances by 4 only once.
4. Instr_D=0x1000_0003 (beq, offset 3) at PCPlus4_D=0x8 with PCSrc_D=1 -> next inst_addr=0x14; Instr_D becomes bubble (0, Valid_D=0). Same case with Stall_D=1 -> no redirect until Stall_D drops.
5. Jump_D=1 with Instr_D=0x0800_0040 and PCPlus4_D=0x1000_0010 while fetch is waiting -> state DISCARD holds the old address until ready; that data is dropped; the next request is to 0x1000_0100.
6. Assert rst mid-stream (in DISCARD/HOLD) -> next cycle inst_addr=RESET_PC, Valid_D=0, Instr_D=0; the stale buffer is never delivered.
